mmu_regions: RTL and testbench

- Programmable successor to the fixed bus address decoder.
- Maps each CPU bus address to a chip select and a cacheable attribute using NREGIONS run-time-programmable base/mask entries.
- Adds a registered decode stage, sticky fault capture (address and cause), and a bus-timeout watchdog.
- Sits between the CPU bus master and the slave chip-select fabric; programmed by boot ROM code through a small config port.

---
 rtl/mmu_regions.sv | 221 ++++++++++++++++++++++
 tb/tb_mmu_regions.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_regions.sv
// rtl/mmu_regions.sv - programmable region decoder with fault capture and bus watchdog
//
// Purpose: maps each CPU bus address to a chip-select code and a cacheable
// attribute through NREGIONS programmable base/mask entries. The decode is
// registered (1-cycle latency). Unmapped accesses and stalled bus cycles
// raise a one-cycle fault pulse. The first uncleared fault is held as a
// sticky address/cause pair.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   adr_i, cyc_i, stb_i bus address, cycle, strobe from the CPU master
//   ack_i               slave acknowledge, feeds the watchdog
//   chipselect          registered chip-select code, 0 = none
//   cache_enable        registered cacheable attribute
//   fault               one-cycle fault pulse
//   fault_cause_o       01 unmapped, 10 timeout
//   fault_adr_o         address of the first uncleared fault
//   fault_pending_o     sticky fault flag
//   fault_clr_i         clears fault_pending_o
//   cfg_we_i, cfg_sel_i, cfg_field_i, cfg_dat_i   config write port
//   cfg_dat_o           combinational readback of the selected field
module mmu_regions #(
   parameter int              AW       = 32,
   parameter int              NREGIONS = 8,
   parameter int              CSW      = 4,
   parameter int              TIMEOUT  = 256,
   parameter logic [AW-1:0]   RST_BASE = 32'hffff0000,
   parameter logic [AW-1:0]   RST_MASK = 32'hffff0000,
   parameter logic [CSW-1:0]  RST_CS   = 4'h2,
   localparam int             SW       = $clog2(NREGIONS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [AW-1:0]   adr_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            ack_i,
   output logic [CSW-1:0]  chipselect,
   output logic            cache_enable,
   output logic            fault,
   output logic [1:0]      fault_cause_o,
   output logic [AW-1:0]   fault_adr_o,
   output logic            fault_pending_o,
   input  logic            fault_clr_i,
   input  logic            cfg_we_i,
   input  logic [SW-1:0]   cfg_sel_i,
   input  logic [1:0]      cfg_field_i,
   input  logic [AW-1:0]   cfg_dat_i,
   output logic [AW-1:0]   cfg_dat_o
);

   // Watchdog counter saturates at TIMEOUT so it never fires twice per stall.
   localparam int             CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  WD_SAT  = CW'(TIMEOUT);

   localparam logic [1:0]     CAUSE_UNMAPPED = 2'b01;
   localparam logic [1:0]     CAUSE_TIMEOUT  = 2'b10;

   // Region table
   logic [NREGIONS-1:0][AW-1:0]  base_q, base_d;
   logic [NREGIONS-1:0][AW-1:0]  mask_q, mask_d;
   logic [NREGIONS-1:0][CSW-1:0] cs_q, cs_d;
   logic [NREGIONS-1:0]          en_q, en_d;
   logic [NREGIONS-1:0]          cach_q, cach_d;

   // Decode, fault and watchdog state
   logic [CSW-1:0]  chipselect_q, chipselect_d;
   logic            cache_enable_q, cache_enable_d;
   logic            fault_q, fault_d;
   logic [1:0]      fault_cause_q, fault_cause_d;
   logic [AW-1:0]   fault_adr_q, fault_adr_d;
   logic            fault_pending_q, fault_pending_d;
   logic [AW-1:0]   last_adr_q, last_adr_d;
   logic            last_unm_q, last_unm_d;
   logic [CW-1:0]   wd_q, wd_d;

   logic            hit;
   logic [CSW-1:0]  hit_cs;
   logic            hit_cach;
   logic            unmapped_evt;
   logic            timeout_evt;

   // Priority match: scan from the top so the lowest matching index is the
   // last one to assign and therefore wins.
   always_comb begin
      hit      = 1'b0;
      hit_cs   = '0;
      hit_cach = 1'b0;
      for (int i = NREGIONS - 1; i >= 0; i--) begin
         if (en_q[i] && ((adr_i & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
            hit      = 1'b1;
            hit_cs   = cs_q[i];
            hit_cach = cach_q[i];
         end
      end
   end

   always_comb begin
      base_d          = base_q;
      mask_d          = mask_q;
      cs_d            = cs_q;
      en_d            = en_q;
      cach_d          = cach_q;
      chipselect_d    = '0;
      cache_enable_d  = 1'b1;
      fault_cause_d   = fault_cause_q;
      fault_adr_d     = fault_adr_q;
      fault_pending_d = fault_pending_q;
      wd_d            = wd_q;
      timeout_evt     = 1'b0;

      // An unmapped address held across consecutive cycles faults only once;
      // dropping cyc_i or moving the address re-arms the check.
      unmapped_evt = cyc_i && !hit && !(last_unm_q && (adr_i == last_adr_q));
      last_unm_d   = cyc_i && !hit;
      last_adr_d   = adr_i;

      if (cyc_i && hit) begin
         chipselect_d   = hit_cs;
         cache_enable_d = hit_cach;
      end

      if (!cyc_i || ack_i) begin
         wd_d = '0;
      end else if (stb_i) begin
         if (wd_q == WD_LAST) begin
            timeout_evt = 1'b1;
            wd_d        = WD_SAT;
         end else if (wd_q != WD_SAT) begin
            wd_d = wd_q + CW'(1);
         end
      end

      fault_d = unmapped_evt || timeout_evt;

      // A coincident clear lets a new fault replace the held one.
      if (fault_d) begin
         if (!fault_pending_q || fault_clr_i) begin
            fault_pending_d = 1'b1;
            fault_adr_d     = adr_i;
            fault_cause_d   = timeout_evt ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
         end
      end else if (fault_clr_i) begin
         fault_pending_d = 1'b0;
      end

      if (cfg_we_i) begin
         case (cfg_field_i)
            2'd0: base_d[cfg_sel_i] = cfg_dat_i;
            2'd1: mask_d[cfg_sel_i] = cfg_dat_i;
            2'd2: begin
               en_d[cfg_sel_i]   = cfg_dat_i[CSW+1];
               cach_d[cfg_sel_i] = cfg_dat_i[CSW];
               cs_d[cfg_sel_i]   = cfg_dat_i[CSW-1:0];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cfg_dat_o = '0;
      case (cfg_field_i)
         2'd0:    cfg_dat_o = base_q[cfg_sel_i];
         2'd1:    cfg_dat_o = mask_q[cfg_sel_i];
         2'd2:    cfg_dat_o = {{(AW-CSW-2){1'b0}}, en_q[cfg_sel_i],
                               cach_q[cfg_sel_i], cs_q[cfg_sel_i]};
         default: cfg_dat_o = fault_adr_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGIONS; i++) begin
            base_q[i] <= '0;
            mask_q[i] <= '0;
            cs_q[i]   <= '0;
            en_q[i]   <= 1'b0;
            cach_q[i] <= 1'b0;
         end
         base_q[0]       <= RST_BASE;
         mask_q[0]       <= RST_MASK;
         cs_q[0]         <= RST_CS;
         en_q[0]         <= 1'b1;
         cach_q[0]       <= 1'b1;
         chipselect_q    <= '0;
         cache_enable_q  <= 1'b1;
         fault_q         <= 1'b0;
         fault_cause_q   <= '0;
         fault_adr_q     <= '0;
         fault_pending_q <= 1'b0;
         last_adr_q      <= '0;
         last_unm_q      <= 1'b0;
         wd_q            <= '0;
      end else begin
         base_q          <= base_d;
         mask_q          <= mask_d;
         cs_q            <= cs_d;
         en_q            <= en_d;
         cach_q          <= cach_d;
         chipselect_q    <= chipselect_d;
         cache_enable_q  <= cache_enable_d;
         fault_q         <= fault_d;
         fault_cause_q   <= fault_cause_d;
         fault_adr_q     <= fault_adr_d;
         fault_pending_q <= fault_pending_d;
         last_adr_q      <= last_adr_d;
         last_unm_q      <= last_unm_d;
         wd_q            <= wd_d;
      end
   end

   assign chipselect      = chipselect_q;
   assign cache_enable    = cache_enable_q;
   assign fault           = fault_q;
   assign fault_cause_o   = fault_cause_q;
   assign fault_adr_o     = fault_adr_q;
   assign fault_pending_o = fault_pending_q;

endmodule

// File: tb/tb_mmu_regions.sv
// tb/tb_mmu_regions.sv - scoreboard bench for mmu_regions with a behavioural table model
module tb_mmu_regions;

   localparam int AW  = 32;
   localparam int NR  = 8;
   localparam int CSW = 4;
   localparam int TO  = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [AW-1:0] adr_i = '0;
   logic          cyc_i = 1'b0;
   logic          stb_i = 1'b0;
   logic          ack_i = 1'b0;
   logic [CSW-1:0] chipselect;
   logic          cache_enable;
   logic          fault;
   logic [1:0]    fault_cause_o;
   logic [AW-1:0] fault_adr_o;
   logic          fault_pending_o;
   logic          fault_clr_i = 1'b0;
   logic          cfg_we_i = 1'b0;
   logic [2:0]    cfg_sel_i = '0;
   logic [1:0]    cfg_field_i = '0;
   logic [AW-1:0] cfg_dat_i = '0;
   logic [AW-1:0] cfg_dat_o;

   mmu_regions #(.AW(AW), .NREGIONS(NR), .CSW(CSW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb_i),
      .ack_i(ack_i), .chipselect(chipselect), .cache_enable(cache_enable),
      .fault(fault), .fault_cause_o(fault_cause_o), .fault_adr_o(fault_adr_o),
      .fault_pending_o(fault_pending_o), .fault_clr_i(fault_clr_i),
      .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_field_i(cfg_field_i),
      .cfg_dat_i(cfg_dat_i), .cfg_dat_o(cfg_dat_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  cs;
      logic        ce;
      logic        flt;
      logic [1:0]  cause;
      logic [31:0] fadr;
      logic        pend;
      logic [31:0] cfg;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_base [NR];
   logic [31:0] m_mask [NR];
   logic [3:0]  m_cs   [NR];
   logic        m_en   [NR];
   logic        m_cach [NR];
   logic        m_pend;
   logic [1:0]  m_cause;
   logic [31:0] m_fadr;
   logic        m_prev_unm;
   logic [31:0] m_prev_adr;
   int          m_stalls;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_base[i] = '0; m_mask[i] = '0; m_cs[i] = '0; m_en[i] = 1'b0; m_cach[i] = 1'b0;
      end
      m_base[0] = 32'hffff0000; m_mask[0] = 32'hffff0000; m_cs[0] = 4'h2;
      m_en[0] = 1'b1; m_cach[0] = 1'b1;
      m_pend = 1'b0; m_cause = 2'b00; m_fadr = '0;
      m_prev_unm = 1'b0; m_prev_adr = '0; m_stalls = 0;
   endtask

   function automatic logic [31:0] m_read(input int sel, input int field);
      case (field)
         0: return m_base[sel];
         1: return m_mask[sel];
         2: return {26'd0, m_en[sel], m_cach[sel], m_cs[sel]};
         default: return m_fadr;
      endcase
   endfunction

   // Called at a negedge with inputs already applied: predicts the outputs
   // after the coming rising edge, queues them, and advances the model.
   task automatic step();
      exp_t e;
      int   hit;
      bit   unm, tmo;
      hit = -1;
      for (int i = 0; i < NR; i++)
         if (hit < 0 && m_en[i] && ((adr_i & m_mask[i]) == (m_base[i] & m_mask[i])))
            hit = i;
      unm = 0; tmo = 0;
      e.cs = 4'h0; e.ce = 1'b1;
      if (cyc_i) begin
         if (hit >= 0) begin
            e.cs = m_cs[hit]; e.ce = m_cach[hit];
         end else begin
            unm = !(m_prev_unm && adr_i == m_prev_adr);
         end
      end
      m_prev_unm = cyc_i && hit < 0;
      m_prev_adr = adr_i;
      if (!cyc_i || ack_i) m_stalls = 0;
      else if (stb_i) begin
         m_stalls++;
         if (m_stalls == TO) tmo = 1;
      end
      e.flt = unm || tmo;
      if (e.flt) begin
         if (!m_pend || fault_clr_i) begin
            m_pend = 1'b1; m_fadr = adr_i; m_cause = tmo ? 2'b10 : 2'b01;
         end
      end else if (fault_clr_i) m_pend = 1'b0;
      if (cfg_we_i) begin
         case (cfg_field_i)
            2'd0: m_base[cfg_sel_i] = cfg_dat_i;
            2'd1: m_mask[cfg_sel_i] = cfg_dat_i;
            2'd2: begin
               m_en[cfg_sel_i] = cfg_dat_i[5]; m_cach[cfg_sel_i] = cfg_dat_i[4];
               m_cs[cfg_sel_i] = cfg_dat_i[3:0];
            end
            default: ;
         endcase
      end
      e.cause = m_cause; e.fadr = m_fadr; e.pend = m_pend;
      e.cfg = m_read(int'(cfg_sel_i), int'(cfg_field_i));
      exp_q.push_back(e);
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic bus(input logic cyc, input logic stb, input logic ack,
                      input logic [31:0] adr, input logic clr);
      cyc_i = cyc; stb_i = stb; ack_i = ack; adr_i = adr; fault_clr_i = clr;
      cfg_we_i = 1'b0;
      step();
      fault_clr_i = 1'b0;
   endtask

   task automatic cfg(input int sel, input int field, input logic [31:0] dat);
      cyc_i = 1'b0; cfg_we_i = 1'b1; cfg_sel_i = 3'(sel); cfg_field_i = 2'(field);
      cfg_dat_i = dat;
      step();
      cfg_we_i = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_cs"}, 32'(chipselect), 32'h0);
      chk({tag, "_ce"}, 32'(cache_enable), 32'h1);
      chk({tag, "_fault"}, 32'(fault), 32'h0);
      chk({tag, "_pend"}, 32'(fault_pending_o), 32'h0);
      chk({tag, "_cause"}, 32'(fault_cause_o), 32'h0);
      chk({tag, "_fadr"}, fault_adr_o, 32'h0);
      cfg_sel_i = 3'd0; cfg_field_i = 2'd0; #1;
      chk({tag, "_e0_base"}, cfg_dat_o, 32'hffff0000);
      cfg_field_i = 2'd1; #1;
      chk({tag, "_e0_mask"}, cfg_dat_o, 32'hffff0000);
      cfg_field_i = 2'd2; #1;
      chk({tag, "_e0_attr"}, cfg_dat_o, 32'h32);
      cfg_sel_i = 3'd1; #1;
      chk({tag, "_e1_attr"}, cfg_dat_o, 32'h0);
   endtask

   // Monitor: compares the queued prediction just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("chipselect", 32'(chipselect), 32'(e.cs));
            chk("cache_enable", 32'(cache_enable), 32'(e.ce));
            chk("fault", 32'(fault), 32'(e.flt));
            chk("fault_cause", 32'(fault_cause_o), 32'(e.cause));
            chk("fault_adr", fault_adr_o, e.fadr);
            chk("fault_pending", 32'(fault_pending_o), 32'(e.pend));
            chk("cfg_dat_o", cfg_dat_o, e.cfg);
         end
      end
   end

   initial begin
      logic [31:0] adr;
      logic [31:0] mask_pool [5];
      mask_pool[0] = 32'hffffff00; mask_pool[1] = 32'hfffff000; mask_pool[2] = 32'hffff0000;
      mask_pool[3] = 32'h00000000; mask_pool[4] = 32'hffffffff;
      model_reset();
      @(negedge clk_i);
      check_reset_state("reset");
      cfg_sel_i = 3'd0; cfg_field_i = 2'd0;
      @(negedge clk_i);
      rst_i = 1'b0;

      // Boot ROM mapping, then an unmapped access held for two cycles
      bus(1, 1, 1, 32'hffff0100, 0);
      bus(1, 1, 1, 32'h00001000, 0);
      bus(1, 1, 1, 32'h00001000, 0);
      bus(0, 0, 0, 32'h00001000, 0);
      bus(1, 1, 1, 32'h00001000, 1);

      // Programmed region, then overlapping lower-index entry
      cfg(1, 0, 32'h00800800);
      cfg(1, 1, 32'hfffff800);
      cfg(1, 2, 32'h24);
      bus(1, 1, 1, 32'h00800810, 1);
      cfg(0, 0, 32'h00800800);
      cfg(0, 1, 32'hfffff800);
      cfg(0, 2, 32'h36);
      cfg(0, 3, 32'h12345678);
      bus(1, 1, 1, 32'h00800810, 0);

      // Sticky capture, clear, and clear coincident with a new fault
      bus(0, 0, 0, 32'h0, 1);
      bus(1, 1, 1, 32'h10, 0);
      bus(1, 1, 1, 32'h20, 0);
      bus(0, 0, 0, 32'h20, 1);
      bus(1, 1, 1, 32'h20, 0);
      bus(1, 1, 1, 32'h30, 1);
      bus(0, 0, 0, 32'h0, 1);

      // Watchdog: six stalled cycles, then a stall broken by ack
      for (int i = 0; i < 6; i++) bus(1, 1, 0, 32'h00800810, 0);
      bus(0, 0, 0, 32'h00800810, 1);
      for (int i = 0; i < 3; i++) bus(1, 1, 0, 32'h00800810, 0);
      bus(1, 1, 1, 32'h00800810, 0);
      for (int i = 0; i < 3; i++) bus(1, 1, 0, 32'h00800810, 0);
      for (int i = 0; i < 4; i++) bus(0, 1, 0, $urandom, 0);

      // Asynchronous reset with a pending fault and programmed entries
      bus(1, 1, 1, 32'h44, 0);
      #3 rst_i = 1'b1;
      #1 check_reset_state("async_rst");
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      cfg_sel_i = 3'd0; cfg_field_i = 2'd0;

      // Randomised traffic
      adr = 32'h0;
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r >= 3 && r < 7) adr = m_base[$urandom_range(0, NR - 1)] | 32'($urandom_range(0, 255));
         else if (r >= 7) adr = 32'($urandom_range(0, 3)) << 4;
         cyc_i = ($urandom_range(0, 9) != 0);
         stb_i = ($urandom_range(0, 4) != 0);
         ack_i = ($urandom_range(0, 3) == 0);
         adr_i = adr;
         fault_clr_i = ($urandom_range(0, 9) == 0);
         cfg_we_i = ($urandom_range(0, 7) == 0);
         cfg_sel_i = 3'($urandom_range(0, NR - 1));
         cfg_field_i = 2'($urandom_range(0, 3));
         case (cfg_field_i)
            2'd0: cfg_dat_i = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hffffff00) : 32'h00800800;
            2'd1: cfg_dat_i = mask_pool[$urandom_range(0, 4)];
            default: cfg_dat_i = 32'($urandom_range(0, 255));
         endcase
         step();
      end
      cfg_we_i = 1'b0; fault_clr_i = 1'b0; cyc_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
